pattern_tx: RTL

PATTERN_TX -- requirements
Module: pattern_tx

---
 rtl/pattern_pkg.sv | 31 +++
 rtl/pattern_tx_if.sv | 22 ++
 rtl/pattern_tx_piso_shift.sv | 34 +++
 rtl/pattern_tx.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern transmitter: FSM encoding,
// sync header default, counter sizing helper and the registered output bundle.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SYNC = 2'b01,
        DATA = 2'b10,
        DONE = 2'b11
    } state_e;

    localparam int unsigned SYNC_LEN = 5;
    localparam int unsigned SIW      = $clog2(SYNC_LEN);

    localparam logic [SYNC_LEN-1:0] SYNC_PAT_DEFAULT = 5'b11010;

    typedef struct packed {
        logic out;
        logic out_valid;
        logic busy;
        logic done;
    } tx_status_t;

    // Counter must hold max(SYNC_LEN, dw) without wrapping.
    function automatic int unsigned cnt_width(input int unsigned dw);
        int unsigned m;
        m = (dw > SYNC_LEN) ? dw : SYNC_LEN;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pattern_tx_if.sv
// Frame request and serial output bundle between a requester and pattern_tx.
interface pattern_tx_if #(
    parameter int unsigned DW = 8
);
    logic          start;
    logic [DW-1:0] data_in;
    logic [3:0]    len;
    logic          out;
    logic          out_valid;
    logic          busy;
    logic          done;

    modport master (
        output start, data_in, len,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  start, data_in, len,
        output out, out_valid, busy, done
    );
endinterface

// File: rtl/pattern_tx_piso_shift.sv
// Parallel-load, shift-left payload register; msb is the next bit to transmit.
module piso_shift #(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          shift,
    input  logic [DW-1:0] data,
    output logic          msb
);

    logic [DW-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = data;
        end else if (shift) begin
            sh_d = sh_q << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb = sh_q[DW-1];

endmodule

// File: rtl/pattern_tx.sv
// Serial frame transmitter: sync header then L payload bits MSB-first,
// followed by a one-cycle done pulse. All outputs come straight from flops.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int unsigned         DW       = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_PAT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    pattern_tx_if.slave bus
);

    localparam int unsigned CW = cnt_width(DW);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] len_q, len_d;
    tx_status_t    st_q, st_d;

    logic          load;
    logic          shift;
    logic          msb;
    logic [CW-1:0] l_eff;
    logic [DW-1:0] load_data;

    // Payload is pre-aligned so bit L-1 sits at the register MSB.
    always_comb begin
        if ((bus.len == '0) || (32'(bus.len) > DW)) begin
            l_eff = CW'(DW);
        end else begin
            l_eff = CW'(bus.len);
        end
        load_data = bus.data_in << (DW - 32'(l_eff));
    end

    // Next-state and registered-output decode; out_d looks one cycle ahead,
    // so the payload register shifts as each bit is committed to st_q.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        st_d    = '0;
        load    = 1'b0;
        shift   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d        = SYNC;
                    cnt_d          = CW'(SYNC_LEN - 1);
                    len_d          = l_eff;
                    load           = 1'b1;
                    st_d.out       = SYNC_PAT[SIW'(SYNC_LEN - 1)];
                    st_d.out_valid = 1'b1;
                    st_d.busy      = 1'b1;
                end
            end
            SYNC: begin
                st_d.busy      = 1'b1;
                st_d.out_valid = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d    = cnt_q - CW'(1);
                    st_d.out = SYNC_PAT[SIW'(cnt_q - CW'(1))];
                end else begin
                    state_d  = DATA;
                    cnt_d    = len_q - CW'(1);
                    st_d.out = msb;
                    shift    = 1'b1;
                end
            end
            DATA: begin
                st_d.busy = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d          = cnt_q - CW'(1);
                    st_d.out       = msb;
                    st_d.out_valid = 1'b1;
                    shift          = 1'b1;
                end else begin
                    state_d   = DONE;
                    cnt_d     = '0;
                    st_d.done = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            st_q    <= st_d;
        end
    end

    piso_shift #(
        .DW (DW)
    ) u_piso (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (shift),
        .data  (load_data),
        .msb   (msb)
    );

    assign bus.out       = st_q.out;
    assign bus.out_valid = st_q.out_valid;
    assign bus.busy      = st_q.busy;
    assign bus.done      = st_q.done;

endmodule
